cpu_instr_sequencer: RTL and testbench
======================================

Name: cpu_instr_sequencer

Overview:
- Synthesisable instruction issue engine that queues encoded instructions and feeds them to the base processor over its DIN/Run/Done interface.
- Issues one instruction at a time. A move-immediate (mvi) gets its second immediate word. The engine waits for Done before issuing the next instruction.
- Generalised successor to the single-shot issue-and-wait loop: parametrised data width, queue depth, mvi opcode and a Done watchdog.
- Sits between a host/bench stimulus port and the processor core.

Parameters:
DATA_W, 16, processor DIN width; must be >= 9.
DEPTH, 8, instruction queue entries; power of two, >= 2.
MVI_OP, 3'b001, opcode that requires a second immediate word.
TIMEOUT, 64, max cycles in WAIT without cpu_done before error; >= 2.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  push request.
in_ready  out  1  queue can accept; equals !full.
in_op  in  3  opcode.
in_rx  in  3  destination register index.
in_ry  in  3  source register index.
in_imm  in  DATA_W  immediate; used only when in_op==MVI_OP.
cpu_din  out  DATA_W  word driven to processor DIN.
cpu_run  out  1  Run strobe to processor.
cpu_done  in  1  processor Done.
clear_err  in  1  acknowledge timeout error.
busy  out  1  FSM not IDLE or queue non-empty.
level  out  $clog2(DEPTH)+1  queue occupancy.
issued_cnt  out  16  completed instructions; wraps 16'hFFFF->0.
timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async assert, sync release): queue empty, level=0, FSM=IDLE, cpu_din=0, cpu_run=0, issued_cnt=0, timeout_err=0, busy=0, in_ready=1.
- Push: occurs when in_valid && in_ready at a rising edge. It stores {op,rx,ry,imm}. When full, in_ready=0 and pushes are ignored; no overwrite.
- Push and pop in the same cycle: level is unchanged. A pop in cycle N makes in_ready=1 in cycle N+1, not combinationally.
- Instruction word: cpu_din = {zeros, op, rx, ry}, with the opcode in bits [8:6], rx in [5:3] and ry in [2:0]. in_imm is passed unmodified.
- FSM states: IDLE, ISSUE, IMM, WAIT, ERR. All outputs are registered.
  - IDLE: when the queue is non-empty, go to ISSUE next edge. A push at edge N into an empty queue gives cpu_run=1 during cycle N+2.
  - ISSUE (1 cycle): cpu_run=1 and cpu_din=instruction word. Next state is IMM if op==MVI_OP, else WAIT.
  - IMM (1 cycle): cpu_run=0 and cpu_din=imm. Next state is WAIT.
  - WAIT: cpu_run=0 and cpu_din holds its last value. The watchdog counter starts at 0 on entry and increments each cycle.
    - On cpu_done=1: pop the head entry, increment issued_cnt, return to IDLE. Done takes priority over timeout in the same cycle.
    - When the counter reaches TIMEOUT-1 with no done: set timeout_err=1 and go to ERR. The entry is not popped.
  - ERR: no issue. On clear_err=1, pop the failing head, clear timeout_err, go to IDLE. issued_cnt does not increment.
- cpu_done outside WAIT is ignored.
- clear_err outside ERR is ignored.
- Back-to-back instructions: a pop at edge N is followed by ISSUE for the next entry at N+2 (one IDLE cycle).
- Asynchronous reset mid-operation aborts immediately. It flushes the queue and drops cpu_run in the same instant; the in-flight instruction is lost.

Test Plan:
- Reset, then push op=3'b000 rx=1 ry=2. Required: cpu_run=1 exactly 2 cycles after the push with cpu_din=16'h000A; assert done 3 cycles later; issued_cnt=1, busy=0.
- Push mvi for rx=0..7 with imm=i, then imm=8'hF0+i. Required: ISSUE word 16'h0040|(i<<3) followed next cycle by cpu_din=imm; 16 completions; issued_cnt=16.
- Push 9 entries back-to-back with DEPTH=8 and done held low. Required: in_ready=0 after the 8th push, level=8, 9th push dropped.
- Hold done low for 64 cycles in WAIT. Required: timeout_err=1, FSM in ERR, level unchanged. Pulse clear_err. Required: level decrements, timeout_err=0, next entry issues.
- Done and timeout in the same cycle. Required: counted as completion, timeout_err stays 0.
- Assert reset during IMM. Required: cpu_run=0, level=0, issued_cnt=0 immediately; after release, a new push issues normally.

Source files
------------

// File: rtl/cpu_instr_sequencer.sv
// Instruction issue engine: queues encoded instructions and drives
// them into the processor DIN/Run/Done handshake one at a time.
module cpu_instr_sequencer #(
    parameter int         DATA_W  = 16,
    parameter int         DEPTH   = 8,
    parameter logic [2:0] MVI_OP  = 3'b001,
    parameter int         TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [2:0]                 in_rx,
    input  logic [2:0]                 in_ry,
    input  logic [DATA_W-1:0]          in_imm,
    output logic [DATA_W-1:0]          cpu_din,
    output logic                       cpu_run,
    input  logic                       cpu_done,
    input  logic                       clear_err,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                issued_cnt,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 9;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        IMM,
        WAIT,
        ERR
    } state_t;

    state_t              state;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [TW-1:0]       wdog;
    logic                full;
    logic                push;
    logic                pop;
    logic [EW-1:0]       head;
    logic [2:0]          head_op;
    logic [DATA_W-1:0]   head_imm;
    logic [DATA_W-1:0]   head_word;

    assign full     = (count == (AW+1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == WAIT && cpu_done) ||
                      (state == ERR && clear_err);
    assign level    = count;
    assign busy     = (state != IDLE) || (count != '0);

    // Entry layout: {op, rx, ry, imm}; the top 9 bits form the DIN word.
    assign head     = mem[rd_ptr];
    assign head_op  = head[EW-1 -: 3];
    assign head_imm = head[DATA_W-1:0];

    always_comb begin
        head_word      = '0;
        head_word[8:0] = head[EW-1 -: 9];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_rx, in_ry, in_imm};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cpu_run     <= 1'b0;
            cpu_din     <= '0;
            issued_cnt  <= '0;
            timeout_err <= 1'b0;
            wdog        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= ISSUE;
                        cpu_run <= 1'b1;
                        cpu_din <= head_word;
                    end
                end
                ISSUE: begin
                    cpu_run <= 1'b0;
                    wdog    <= '0;
                    if (head_op == MVI_OP) begin
                        state   <= IMM;
                        cpu_din <= head_imm;
                    end else begin
                        state <= WAIT;
                    end
                end
                IMM: begin
                    state <= WAIT;
                    wdog  <= '0;
                end
                WAIT: begin
                    // Done wins over a watchdog expiry in the same cycle.
                    if (cpu_done) begin
                        state      <= IDLE;
                        issued_cnt <= issued_cnt + 16'd1;
                    end else if (wdog == TW'(TIMEOUT - 1)) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ERR: begin
                    if (clear_err) begin
                        state       <= IDLE;
                        timeout_err <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Self-checking bench for cpu_instr_sequencer: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_cpu_instr_sequencer;

    localparam int         DATA_W  = 16;
    localparam int         DEPTH   = 8;
    localparam int         TIMEOUT = 64;
    localparam logic [2:0] MVI     = 3'b001;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [2:0]        in_rx;
    logic [2:0]        in_ry;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_run;
    logic              cpu_done;
    logic              clear_err;
    logic              busy;
    logic [3:0]        level;
    logic [15:0]       issued_cnt;
    logic              timeout_err;

    always #5 clock = ~clock;

    cpu_instr_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MVI_OP (MVI),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rx      (in_rx),
        .in_ry      (in_ry),
        .in_imm     (in_imm),
        .cpu_din    (cpu_din),
        .cpu_run    (cpu_run),
        .cpu_done   (cpu_done),
        .clear_err  (clear_err),
        .busy       (busy),
        .level      (level),
        .issued_cnt (issued_cnt),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] imm;
        logic [15:0] exp_word;
    } vec_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] imm;
    } ent_t;

    vec_t vecs[19];
    ent_t exp_q[$];
    ent_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] word_of(input logic [2:0] op,
                                            input logic [2:0] rx,
                                            input logic [2:0] ry);
        return 16'(op) * 16'd64 + 16'(rx) * 16'd8 + 16'(ry);
    endfunction

    task automatic set_fields(input logic [2:0] op, input logic [2:0] rx,
                              input logic [2:0] ry, input logic [15:0] imm);
        in_op  = op;
        in_rx  = rx;
        in_ry  = ry;
        in_imm = imm;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        cpu_done  = 1'b0;
        clear_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int stall;
        bit inflight;
        bit pend_imm;
        bit accept;
        bit drive_done;
        int completions;

        vecs[0] = '{3'd0, 3'd1, 3'd2, 16'h0000, 16'h000A};
        for (int i = 0; i < 16; i++) begin
            vecs[1+i].op       = MVI;
            vecs[1+i].rx       = 3'(i % 8);
            vecs[1+i].ry       = 3'd0;
            vecs[1+i].imm      = (i < 8) ? 16'(i) : 16'(16'hF0 + i - 8);
            vecs[1+i].exp_word = 16'h0040 | 16'((i % 8) << 3);
        end
        vecs[17] = '{3'd7, 3'd7, 3'd7, 16'h1234, 16'h01FF};
        vecs[18] = '{3'd2, 3'd3, 3'd5, 16'h0000, 16'h009D};

        set_fields(3'd0, 3'd0, 3'd0, 16'h0);
        do_reset();
        check("rst_level", level, 0);
        check("rst_run", cpu_run, 0);
        check("rst_din", cpu_din, 0);
        check("rst_cnt", issued_cnt, 0);
        check("rst_err", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);

        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("idle_done_cnt", issued_cnt, 0);
        check("idle_done_busy", busy, 0);

        for (int i = 0; i < 19; i++) begin
            set_fields(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].imm);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("vec_run_early", cpu_run, 0);
            tick();
            check("vec_run", cpu_run, 1);
            check("vec_word", cpu_din, vecs[i].exp_word);
            tick();
            check("vec_run_low", cpu_run, 0);
            check("vec_din2", cpu_din,
                  (vecs[i].op == MVI) ? vecs[i].imm : vecs[i].exp_word);
            clear_err = 1'b1;
            tick();
            clear_err = 1'b0;
            check("vec_clr_ignored", level, 1);
            cpu_done = 1'b1;
            tick();
            cpu_done = 1'b0;
            check("vec_cnt", issued_cnt, i + 1);
            check("vec_level", level, 0);
            check("vec_busy", busy, 0);
        end

        set_fields(MVI, 3'd5, 3'd0, 16'hBEEF);
        in_valid = 1'b1;
        tick();
        set_fields(3'd2, 3'd1, 3'd1, 16'h0);
        tick();
        in_valid = 1'b0;
        check("imm_rst_issue", cpu_din, 16'h0068);
        check("imm_rst_level", level, 2);
        tick();
        check("imm_rst_in_imm", cpu_din, 16'hBEEF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_run", cpu_run, 0);
        check("async_rst_level", level, 0);
        check("async_rst_cnt", issued_cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        set_fields(3'd4, 3'd2, 3'd3, 16'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_run_early", cpu_run, 0);
        tick();
        check("post_rst_run", cpu_run, 1);
        check("post_rst_word", cpu_din, 16'h0113);
        tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("post_rst_cnt", issued_cnt, 1);

        in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            set_fields(3'd0, 3'(k), 3'd1, 16'h0);
            tick();
            if (k == 1) check("fill_issue", cpu_run, 1);
            if (k == 7) begin
                check("full_ready", in_ready, 0);
                check("full_level", level, 8);
            end
        end
        in_valid = 1'b0;
        check("drop_level", level, 8);
        n = 7;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TIMEOUT + 1);
        check("timeout_err", timeout_err, 1);
        check("timeout_level", level, 8);
        check("timeout_busy", busy, 1);
        cpu_done = 1'b1;
        repeat (3) tick();
        cpu_done = 1'b0;
        check("err_done_ignored", issued_cnt, 1);
        check("err_no_issue", cpu_run, 0);
        check("err_level", level, 8);
        check("err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_err", timeout_err, 0);
        check("clr_level", level, 7);
        check("clr_ready", in_ready, 1);
        check("clr_cnt", issued_cnt, 1);
        tick();
        check("clr_next_run", cpu_run, 1);
        check("clr_next_word", cpu_din, 16'h0009);

        for (int j = 0; j < TIMEOUT; j++) tick();
        check("edge_err_before", timeout_err, 0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("edge_err_after", timeout_err, 0);
        check("edge_cnt", issued_cnt, 2);
        check("edge_level", level, 6);
        tick();
        check("edge_next_run", cpu_run, 1);
        check("edge_next_word", cpu_din, 16'h0011);

        do_reset();
        exp_q.delete();
        completions = 0;
        inflight    = 1'b0;
        pend_imm    = 1'b0;
        stall       = 0;
        cnt         = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pend_imm) begin
                check("rnd_imm", cpu_din, cur.imm);
                check("rnd_imm_run", cpu_run, 0);
                pend_imm = 1'b0;
            end
            if (cpu_run) begin
                if (inflight || exp_q.size() == 0) begin
                    check("rnd_run_unexpected", cpu_run, 0);
                end else begin
                    cur = exp_q[0];
                    check("rnd_word", cpu_din, word_of(cur.op, cur.rx, cur.ry));
                    check("rnd_latency", stall, 1);
                    inflight = 1'b1;
                    pend_imm = (cur.op == MVI);
                    cnt      = 1 + int'(pend_imm) + int'($urandom_range(0, 4));
                    stall    = 0;
                end
            end else if (!inflight && exp_q.size() > 0) begin
                stall++;
                if (stall >= 2) begin
                    check("rnd_issue_stall", stall, 1);
                    stall = 0;
                end
            end
            check("rnd_level", level, exp_q.size());
            check("rnd_ready", in_ready, exp_q.size() < DEPTH);
            check("rnd_busy", busy, exp_q.size() > 0);
            check("rnd_cnt", issued_cnt, 16'(completions));
            check("rnd_err", timeout_err, 0);

            drive_done = 1'b0;
            if (inflight) begin
                if (cnt == 0) drive_done = 1'b1;
                else cnt--;
            end
            cpu_done  = drive_done ||
                        (!inflight && $urandom_range(0, 3) == 0);
            clear_err = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            set_fields(($urandom_range(0, 9) < 3) ? MVI : 3'($urandom),
                       3'($urandom), 3'($urandom), 16'($urandom));
            accept = in_valid && (exp_q.size() < DEPTH);
            tick();
            if (accept) exp_q.push_back({in_op, in_rx, in_ry, in_imm});
            if (drive_done) begin
                void'(exp_q.pop_front());
                completions++;
                inflight = 1'b0;
            end
        end
        in_valid  = 1'b0;
        cpu_done  = 1'b0;
        clear_err = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
